// File: rtl/ttl_555_prog.sv
// 555-timer emulation (astable / monostable) counting ce ticks; outputs are registered, 1-cycle latency.
// No backpressure: ce only gates counting, and trigger edges are sampled every cycle.
module ttl_555_prog #(
    parameter int WIDTH     = 16,
    parameter int RETRIGGER = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             mode,
    input  logic             trigger,
    input  logic             inhibit,
    input  logic [WIDTH-1:0] high_count,
    input  logic [WIDTH-1:0] low_count,
    output logic             out,
    output logic             busy,
    output logic             phase_end
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             trig_prev_q, trig_prev_d;
    logic             phase_end_q, phase_end_d;

    logic             trig_edge;
    logic [WIDTH-1:0] hi_load;
    logic [WIDTH-1:0] lo_load;

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        trig_prev_q <= trig_prev_d;
        phase_end_q <= phase_end_d;
    end

    always_comb begin
        trig_edge   = trigger & ~trig_prev_q;
        // A zero duration still occupies one tick.
        hi_load     = (high_count == '0) ? '0 : high_count - ONE;
        lo_load     = (low_count  == '0) ? '0 : low_count  - ONE;

        state_d     = state_q;
        cnt_d       = cnt_q;
        trig_prev_d = trigger;
        phase_end_d = 1'b0;

        if (reset) begin
            state_d     = IDLE;
            cnt_d       = '0;
            trig_prev_d = 1'b0;
        end else if (inhibit) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!mode || trig_edge) begin
                        state_d = HIGH;
                        cnt_d   = hi_load;
                    end
                end
                HIGH: begin
                    // A retrigger reload beats a same-cycle terminal exit.
                    if (mode && (RETRIGGER != 0) && trig_edge) begin
                        cnt_d = hi_load;
                    end else if (ce) begin
                        if (cnt_q == '0) begin
                            phase_end_d = 1'b1;
                            if (mode) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end else begin
                                state_d = LOW;
                                cnt_d   = lo_load;
                            end
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                LOW: begin
                    if (ce) begin
                        if (cnt_q == '0) begin
                            if (mode) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end else begin
                                state_d = HIGH;
                                cnt_d   = hi_load;
                            end
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign out       = (state_q == HIGH);
    assign busy      = (state_q == HIGH) || (state_q == LOW);
    assign phase_end = phase_end_q;

endmodule

// File: tb/tb_ttl_555_prog.sv
module tb_ttl_555_prog;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        mode;
    logic        trigger;
    logic        inhibit;
    logic [15:0] high_count;
    logic [15:0] low_count;
    logic        out0, busy0, pe0;
    logic        out1, busy1, pe1;

    int checks;
    int errors;

    ttl_555_prog #(.WIDTH(16), .RETRIGGER(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .mode       (mode),
        .trigger    (trigger),
        .inhibit    (inhibit),
        .high_count (high_count),
        .low_count  (low_count),
        .out        (out0),
        .busy       (busy0),
        .phase_end  (pe0)
    );

    ttl_555_prog #(.WIDTH(16), .RETRIGGER(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .mode       (mode),
        .trigger    (trigger),
        .inhibit    (inhibit),
        .high_count (high_count),
        .low_count  (low_count),
        .out        (out1),
        .busy       (busy1),
        .phase_end  (pe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_astable();
        logic exp_out, exp_pe;
        mode = 1'b0; ce = 1'b1; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd3; low_count = 16'd2;
        do_reset();
        checks++;
        if (out0 !== 1'b0 || busy0 !== 1'b0 || pe0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%b busy=%b pe=%b want 0/0/0", out0, busy0, pe0);
        end
        for (int e = 1; e <= 10; e++) begin
            step();
            exp_out = ((e - 1) % 5) < 3;
            exp_pe  = ((e - 1) % 5) == 3;
            checks++;
            if (out0 !== exp_out || pe0 !== exp_pe) begin
                errors++;
                $display("FAIL astable_3_2 cyc=%0d out=%b pe=%b want %b/%b", e, out0, pe0, exp_out, exp_pe);
            end
        end
    endtask

    task automatic test_ce_gating();
        logic exp_out;
        mode = 1'b0; ce = 1'b0; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd4; low_count = 16'd4;
        do_reset();
        for (int e = 1; e <= 47; e++) begin
            ce = (e % 3 == 0);
            step();
            exp_out = (e < 12) ? 1'b1 : (((e - 12) / 12) % 2 == 1);
            checks++;
            if (out0 !== exp_out || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL ce_gating cyc=%0d out=%b busy=%b want %b/1", e, out0, busy0, exp_out);
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_mono_noretrig();
        logic exp_out, exp_pe;
        mode = 1'b1; ce = 1'b1; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd5; low_count = 16'd1;
        do_reset();
        step();
        checks++;
        if (out0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL mono_idle out=%b busy=%b want 0/0", out0, busy0);
        end
        for (int i = 0; i < 12; i++) begin
            trigger = (i == 0) || (i >= 2);
            step();
            exp_out = (i <= 4);
            exp_pe  = (i == 5);
            checks++;
            if (out0 !== exp_out || pe0 !== exp_pe) begin
                errors++;
                $display("FAIL mono_noretrig i=%0d out=%b pe=%b want %b/%b", i, out0, pe0, exp_out, exp_pe);
            end
        end
        trigger = 1'b0;
        step();
    endtask

    task automatic test_mono_retrig();
        logic exp_out1, exp_out0, exp_pe;
        mode = 1'b1; ce = 1'b1; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd5;
        do_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            trigger = (i == 0) || (i == 3);
            step();
            exp_out1 = (i <= 7);
            exp_out0 = (i <= 4);
            checks++;
            if (out1 !== exp_out1 || out0 !== exp_out0) begin
                errors++;
                $display("FAIL mono_retrig i=%0d out_rt=%b out_nrt=%b want %b/%b", i, out1, out0, exp_out1, exp_out0);
            end
        end
        trigger = 1'b0;
        step();
        // Second edge lands on the terminal tick of the first HIGH.
        for (int i = 0; i < 12; i++) begin
            trigger = (i == 0) || (i == 5);
            step();
            exp_out1 = (i <= 9);
            exp_pe   = (i == 10);
            checks++;
            if (out1 !== exp_out1 || pe1 !== exp_pe) begin
                errors++;
                $display("FAIL retrig_terminal i=%0d out=%b pe=%b want %b/%b", i, out1, pe1, exp_out1, exp_pe);
            end
        end
        trigger = 1'b0;
    endtask

    task automatic test_zero_and_resample();
        logic exp_out;
        mode = 1'b0; ce = 1'b1; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd0; low_count = 16'd0;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            high_count = (e >= 8) ? 16'd6 : 16'd0;
            step();
            if (e <= 8)       exp_out = (e % 2 == 1);
            else if (e <= 14) exp_out = 1'b1;
            else              exp_out = (e == 16);
            checks++;
            if (out0 !== exp_out) begin
                errors++;
                $display("FAIL zero_resample cyc=%0d out=%b want %b", e, out0, exp_out);
            end
        end
    endtask

    task automatic test_inhibit_and_reset();
        mode = 1'b0; ce = 1'b1; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd5; low_count = 16'd5;
        do_reset();
        step();
        step();
        checks++;
        if (out0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_inhibit out=%b want 1", out0);
        end
        inhibit = 1'b1;
        step();
        checks++;
        if (out0 !== 1'b0 || busy0 !== 1'b0 || pe0 !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_high out=%b busy=%b pe=%b want 0/0/0", out0, busy0, pe0);
        end
        mode = 1'b1;
        step();
        trigger = 1'b1;
        step();
        step();
        inhibit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out0 !== 1'b0 || out1 !== 1'b0) begin
                errors++;
                $display("FAIL trig_held_release i=%0d out=%b/%b want 0/0", i, out0, out1);
            end
        end
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        checks++;
        if (out0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL trig_refire out=%b busy=%b want 1/1", out0, busy0);
        end
        trigger = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (out0 !== 1'b0) begin
            errors++;
            $display("FAIL mono_done out=%b want 0", out0);
        end
        reset = 1'b1;
        trigger = 1'b1;
        step();
        checks++;
        if (out0 !== 1'b0 || busy0 !== 1'b0 || out1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_trig out=%b busy=%b out_rt=%b want 0/0/0", out0, busy0, out1);
        end
        reset = 1'b0;
        trigger = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; ce = 1'b0; mode = 1'b0; trigger = 1'b0; inhibit = 1'b0;
        high_count = 16'd1; low_count = 16'd1;
        test_reset_astable();
        test_ce_gating();
        test_mono_noretrig();
        test_mono_retrig();
        test_zero_and_resample();
        test_inhibit_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
